lieat_ifu_fetchq: RTL and testbench
===================================

# lieat_ifu_fetchq

Parametrised fetch front-end: sequential PC generator, credit-limited multi-outstanding request issue to the icache, and a DEPTH-entry instruction queue feeding IDU. It replaces single-outstanding fetch: up to DEPTH requests are in flight while IDU stalls, and flushes discard stale responses by kill-counting. It sits between the BPU/EXU redirect sources and the IDU.

## Interface
- XLEN, 32, data/address width
- DEPTH, 4, queue entries and maximum in-flight requests (power of two, ≥2)
- RST_PC, 32'h8000_0000, first fetch address after reset
---
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  out  1  fetch request to icache
- req_ready  in  1  icache accepts request
- req_pc  out  XLEN  request address
- rsp_valid  in  1  icache response (in request order, one per accepted request)
- rsp_ready  out  1  tied 1; responses are never back-pressured
- rsp_inst  in  XLEN  fetched instruction
- out_valid  out  1  instruction to IDU
- out_ready  in  1  IDU accepts
- out_pc  out  XLEN  PC of out_inst
- out_inst  out  XLEN  instruction
- flush  in  1  redirect (EXU mispredict/fence.i completion)
- flush_pc  in  XLEN  redirect target
- stall  in  1  block new issue (jalr dependency, fence.i wait)
- occupancy  out  $clog2(DEPTH)+1  valid queue entries

## Operation
- State: fetch_pc, queue (pc+inst per entry, rd/wr pointers with wrap bit), inflight counter (live requests), kill counter (stale requests), pc FIFO of in-flight request PCs (DEPTH deep).
- Issue condition: req_valid = ~rst & ~stall & ~flush & (occupancy + inflight < DEPTH) & (inflight + kill < DEPTH). req_pc = fetch_pc.
- On req handshake: fetch_pc += 4 (wraps mod 2^XLEN), inflight++, req_pc pushed to pc FIFO.
- On rsp_valid: if kill ≠ 0 → kill--, response dropped. Else inflight--, {pc FIFO head, rsp_inst} pushed to queue (or bypassed, see Configuration). Credit rule guarantees the queue never overflows.
- On out handshake: queue pops.
- Flush (highest priority): queue emptied, pc FIFO emptied, fetch_pc ← flush_pc, kill ← kill + inflight − (rsp_valid & kill==0 ? 1 : 0)... precisely: the response arriving in the flush cycle is treated as stale (dropped, decrements the combined count); inflight ← 0. out_valid is forced 0 in the flush cycle.
- Simultaneous push and pop with full queue: allowed, occupancy unchanged.
- stall only blocks issue; queued entries still drain, responses still land.

## Timing
- Reset values: req_valid 0, req_pc RST_PC, out_valid 0, out_pc 0, out_inst 0, occupancy 0, rsp_ready 1; counters 0.
- First req_valid high in the first cycle after rst deasserts (with stall=0).
- Issue throughput: one request per cycle while credits remain.
- Response → out_valid: next cycle (queue registered); 0 cycles with bypass.
- Flush → first request with flush_pc: next cycle.
- Reset asserted mid-operation: all state cleared asynchronously; in-flight icache responses after reset are the icache's responsibility (icache is reset by the same rst).

## Configuration
- LIEAT_FETCHQ_BYPASS_EN defined: when queue empty, kill==0, rsp_valid and out_ready (no flush), response drives out_* combinationally in the same cycle and is not written to the queue; if out_ready low it is enqueued as normal.
- Undefined: every response goes through the queue; minimum response-to-IDU latency 1 cycle; out_* purely registered.

## Test plan
- Reset release, req_ready=1, icache 1-cycle latency, out_ready=1 → req_pc 0x80000000, 0x80000004, 0x80000008… and out_pc in the same order, one per cycle steady state.
- out_ready=0, DEPTH=4 → exactly 4 requests accepted, occupancy reaches 4, req_valid stays 0; one out_ready pulse → exactly one new request.
- 3 requests in flight, flush with flush_pc=0x80001000 → next req_pc 0x80001000; the 3 stale responses dropped (kill 3→0); first out_pc 0x80001000.
- Flush in the same cycle as rsp_valid and out_ready → that response dropped, out_valid 0 that cycle, queue empty next cycle.
- stall=1 for 5 cycles with 2 queued entries → no req_valid; both entries delivered; issue resumes the cycle after stall falls at the next sequential PC.
- With LIEAT_FETCHQ_BYPASS_EN: empty queue, rsp_valid with inst 0x00000013 and out_ready=1 → out_valid and out_inst=0x00000013 in the same cycle, occupancy stays 0; without macro → out_valid one cycle later.

Source files
------------

// File: rtl/lieat_ifu_fetchq_if.sv
// lieat_ifu_fetchq_if: icache request/response, IDU output, and redirect signals for the fetch queue
interface lieat_ifu_fetchq_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic [XLEN-1:0]         req_pc;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [XLEN-1:0]         rsp_inst;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_pc;
  logic [XLEN-1:0]         out_inst;
  logic                    flush;
  logic [XLEN-1:0]         flush_pc;
  logic                    stall;
  logic [$clog2(DEPTH):0]  occupancy;
  modport master (
    output req_valid, req_pc, rsp_ready, out_valid, out_pc, out_inst, occupancy,
    input  req_ready, rsp_valid, rsp_inst, out_ready, flush, flush_pc, stall
  );
  modport slave (
    input  req_valid, req_pc, rsp_ready, out_valid, out_pc, out_inst, occupancy,
    output req_ready, rsp_valid, rsp_inst, out_ready, flush, flush_pc, stall
  );
endinterface

// File: rtl/lieat_ifu_fetchq.sv
// lieat_ifu_fetchq: credit-limited multi-outstanding fetch with kill-counted flush and DEPTH-entry queue.
// Optional same-cycle response bypass to IDU when LIEAT_FETCHQ_BYPASS_EN is defined.
module lieat_ifu_fetchq #(
  parameter int              XLEN   = 32,
  parameter int              DEPTH  = 4,
  parameter logic [XLEN-1:0] RST_PC = 32'h8000_0000
) (
  input logic                clk,
  input logic                rst,
  lieat_ifu_fetchq_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d, kill_q, kill_d;
  logic [CW-1:0]   wr_q, wr_d, rd_q, rd_d, pw_q, pw_d, pr_q, pr_d, occ;
  logic [XLEN-1:0] q_pc [DEPTH];
  logic [XLEN-1:0] q_inst [DEPTH];
  logic [XLEN-1:0] pf_pc [DEPTH];
  logic            kill_z, req_fire, rsp_live, byp, push, pop, stale_rsp;
  assign occ            = wr_q - rd_q;
  assign kill_z         = kill_q == '0;
  assign bus.rsp_ready  = 1'b1;
  assign bus.req_pc     = fetch_pc_q;
  assign bus.occupancy  = occ;
  assign bus.req_valid  = ~rst & ~bus.stall & ~bus.flush
                        & (({1'b0, occ} + {1'b0, inflight_q}) < (CW+1)'(DEPTH))
                        & (({1'b0, inflight_q} + {1'b0, kill_q}) < (CW+1)'(DEPTH));
  assign req_fire       = bus.req_valid & bus.req_ready;
  assign rsp_live       = bus.rsp_valid & kill_z & ~bus.flush;
`ifdef LIEAT_FETCHQ_BYPASS_EN
  assign byp            = rsp_live & (occ == '0) & bus.out_ready;
  assign bus.out_valid  = ~bus.flush & ((occ != '0) | byp);
  assign bus.out_pc     = byp ? pf_pc[pr_q[AW-1:0]] : q_pc[rd_q[AW-1:0]];
  assign bus.out_inst   = byp ? bus.rsp_inst : q_inst[rd_q[AW-1:0]];
`else
  assign byp            = 1'b0;
  assign bus.out_valid  = ~bus.flush & (occ != '0);
  assign bus.out_pc     = q_pc[rd_q[AW-1:0]];
  assign bus.out_inst   = q_inst[rd_q[AW-1:0]];
`endif
  assign push           = rsp_live & ~byp;
  assign pop            = bus.out_valid & bus.out_ready & ~byp;
  // a response landing in the flush cycle is stale and consumes one of the transferred credits
  assign stale_rsp      = bus.rsp_valid & ((kill_q != '0) | (inflight_q != '0));
  always_comb begin
    fetch_pc_d = bus.flush ? bus.flush_pc : req_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    inflight_d = bus.flush ? '0 : inflight_q + CW'(req_fire) - CW'(rsp_live);
    kill_d     = bus.flush ? kill_q + inflight_q - CW'(stale_rsp) : kill_q - CW'(bus.rsp_valid & ~kill_z);
    wr_d       = bus.flush ? '0 : wr_q + CW'(push);
    rd_d       = bus.flush ? '0 : rd_q + CW'(pop);
    pw_d       = bus.flush ? '0 : pw_q + CW'(req_fire);
    pr_d       = bus.flush ? '0 : pr_q + CW'(rsp_live);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_pc_q <= RST_PC;
      inflight_q <= '0;
      kill_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      pw_q       <= '0;
      pr_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
        pf_pc[i]  <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      pw_q       <= pw_d;
      pr_q       <= pr_d;
      if (push) begin
        q_pc[wr_q[AW-1:0]]   <= pf_pc[pr_q[AW-1:0]];
        q_inst[wr_q[AW-1:0]] <= bus.rsp_inst;
      end
      if (req_fire) pf_pc[pw_q[AW-1:0]] <= fetch_pc_q;
    end
endmodule

// File: tb/tb_lieat_ifu_fetchq.sv
// tb_lieat_ifu_fetchq: directed bench with an in-order 1-cycle icache model and an IDU handshake log
module tb_lieat_ifu_fetchq;
  localparam logic [31:0] K = 32'h8000_0013;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ic_en = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_out;
  logic [31:0] pend[$];
  logic [31:0] req_log[$];
  logic [31:0] opc_log[$];
  logic [31:0] oin_log[$];
  int ocyc_log[$];
  lieat_ifu_fetchq_if #(.XLEN(32), .DEPTH(4)) bus();
  lieat_ifu_fetchq #(.XLEN(32), .DEPTH(4), .RST_PC(32'h8000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    bus.rsp_valid = 1'b0;
    bus.rsp_inst  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) pend.delete();
      else begin
        if (bus.rsp_valid) void'(pend.pop_front());
        if (bus.req_valid && bus.req_ready) begin
          pend.push_back(bus.req_pc);
          req_log.push_back(bus.req_pc);
        end
        if (bus.out_valid && bus.out_ready) begin
          opc_log.push_back(bus.out_pc);
          oin_log.push_back(bus.out_inst);
          ocyc_log.push_back(cyc);
        end
      end
      @(negedge clk);
      bus.rsp_valid = !rst && ic_en && pend.size() > 0;
      bus.rsp_inst  = pend.size() > 0 ? pend[0] ^ K : '0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ic_en = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.req_ready = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    req_log.delete();
    opc_log.delete();
    oin_log.delete();
    ocyc_log.delete();
    rst = 1'b0;
  endtask
  initial begin
    bus.req_ready = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.flush_pc  = '0;
    bus.stall     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(bus.req_valid), 0);
    chk("rst_req_pc", bus.req_pc, 32'h8000_0000);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_pc", bus.out_pc, 0);
    chk("rst_out_inst", bus.out_inst, 0);
    chk("rst_occupancy", 32'(bus.occupancy), 0);
    chk("rst_rsp_ready", 32'(bus.rsp_ready), 1);
    // sequential streaming
    @(negedge clk);
    rst = 1'b0;
    bus.req_ready = 1'b1;
    bus.out_ready = 1'b1;
    ic_en = 1'b1;
    #1;
    chk("s1_first_req_valid", 32'(bus.req_valid), 1);
    chk("s1_first_req_pc", bus.req_pc, 32'h8000_0000);
    repeat (8) @(negedge clk);
    #1;
    chk("s1_req_cnt_ge4", 32'(req_log.size() >= 4), 1);
    chk("s1_out_cnt_ge4", 32'(opc_log.size() >= 4), 1);
    chk("s1_req0", req_log[0], 32'h8000_0000);
    chk("s1_req1", req_log[1], 32'h8000_0004);
    chk("s1_req2", req_log[2], 32'h8000_0008);
    chk("s1_req3", req_log[3], 32'h8000_000C);
    chk("s1_out0", opc_log[0], 32'h8000_0000);
    chk("s1_out1", opc_log[1], 32'h8000_0004);
    chk("s1_out2", opc_log[2], 32'h8000_0008);
    chk("s1_inst0", oin_log[0], 32'h0000_0013);
    chk("s1_inst2", oin_log[2], 32'h0000_001B);
    chk("s1_one_per_cycle", 32'(ocyc_log[3] - ocyc_log[0]), 3);
    // IDU stalled: credits cap issue at DEPTH
    do_reset();
    bus.req_ready = 1'b1;
    ic_en = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("s2_req_cnt", 32'(req_log.size()), 4);
    chk("s2_occ_full", 32'(bus.occupancy), 4);
    chk("s2_req_blocked", 32'(bus.req_valid), 0);
    chk("s2_out_valid", 32'(bus.out_valid), 1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("s2_req_cnt_after_pulse", 32'(req_log.size()), 5);
    chk("s2_req4", req_log[4], 32'h8000_0010);
    chk("s2_out_cnt", 32'(opc_log.size()), 1);
    chk("s2_out0", opc_log[0], 32'h8000_0000);
    chk("s2_occ_refull", 32'(bus.occupancy), 4);
    chk("s2_head_pc", bus.out_pc, 32'h8000_0004);
    // flush with 3 requests in flight
    do_reset();
    bus.req_ready = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.req_ready = 1'b0;
    #1;
    chk("s3_inflight_cnt", 32'(req_log.size()), 3);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.flush_pc = 32'h8000_1000;
    #1;
    chk("s3_flush_out_valid", 32'(bus.out_valid), 0);
    chk("s3_flush_req_valid", 32'(bus.req_valid), 0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.req_ready = 1'b1;
    ic_en = 1'b1;
    #1;
    chk("s3_req_valid", 32'(bus.req_valid), 1);
    chk("s3_req_pc", bus.req_pc, 32'h8000_1000);
    repeat (12) @(negedge clk);
    #1;
    chk("s3_out_cnt_ge2", 32'(opc_log.size() >= 2), 1);
    chk("s3_out0_pc", opc_log[0], 32'h8000_1000);
    chk("s3_out0_inst", oin_log[0], 32'h0000_1013);
    chk("s3_out1_pc", opc_log[1], 32'h8000_1004);
    // flush coinciding with a response and out_ready
    do_reset();
    bus.req_ready = 1'b1;
    bus.out_ready = 1'b1;
    ic_en = 1'b1;
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    bus.flush_pc = 32'h8000_2000;
    #1;
    chk("s4_flush_out_valid", 32'(bus.out_valid), 0);
    n_out = opc_log.size();
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("s4_no_out_in_flush", 32'(opc_log.size()), 32'(n_out));
    chk("s4_occ_empty", 32'(bus.occupancy), 0);
    chk("s4_out_valid_after", 32'(bus.out_valid), 0);
    chk("s4_req_pc", bus.req_pc, 32'h8000_2000);
    repeat (5) @(negedge clk);
    #1;
    chk("s4_first_after_flush", opc_log[n_out], 32'h8000_2000);
    // stall with two queued entries
    do_reset();
    bus.req_ready = 1'b1;
    ic_en = 1'b1;
    repeat (2) @(negedge clk);
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s5_stall_req_valid", 32'(bus.req_valid), 0);
      if (i == 1) begin
        chk("s5_occ_two", 32'(bus.occupancy), 2);
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
    end
    bus.stall = 1'b0;
    #1;
    chk("s5_resume_valid", 32'(bus.req_valid), 1);
    chk("s5_resume_pc", bus.req_pc, 32'h8000_0008);
    chk("s5_out_cnt", 32'(opc_log.size()), 2);
    chk("s5_out0", opc_log[0], 32'h8000_0000);
    chk("s5_out1", opc_log[1], 32'h8000_0004);
    chk("s5_occ_drained", 32'(bus.occupancy), 0);
    // response latency to IDU
    do_reset();
    bus.req_ready = 1'b1;
    bus.out_ready = 1'b1;
    ic_en = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    #1;
`ifdef LIEAT_FETCHQ_BYPASS_EN
    chk("s6_byp_out_valid", 32'(bus.out_valid), 1);
    chk("s6_byp_out_inst", bus.out_inst, 32'h0000_0013);
    chk("s6_byp_occ", 32'(bus.occupancy), 0);
    @(negedge clk);
    #1;
    chk("s6_byp_occ_after", 32'(bus.occupancy), 0);
    chk("s6_byp_out_cnt", 32'(opc_log.size()), 1);
`else
    chk("s6_out_valid_same", 32'(bus.out_valid), 0);
    chk("s6_occ_same", 32'(bus.occupancy), 0);
    @(negedge clk);
    #1;
    chk("s6_out_valid_next", 32'(bus.out_valid), 1);
    chk("s6_out_inst_next", bus.out_inst, 32'h0000_0013);
    chk("s6_occ_next", 32'(bus.occupancy), 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
